// File: rtl/mul_issue_if.sv
// -----------------------------------------------------------------------------
// mul_issue_if
// Purpose : groups the two valid/ready channels of the MUL issue stage.
//           The "in" channel carries an RV32M MUL op from execute; the "out"
//           channel carries the captured product and rd tag to writeback.
// Signals : in_valid/in_ready/in_a/in_x/in_tag        execute -> issue stage
//           out_valid/out_ready/out_result/out_tag    issue stage -> writeback
// Modports: master - the environment (execute + writeback side)
//           slave  - the issue controller
// -----------------------------------------------------------------------------
interface mul_issue_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_x;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_x, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_x, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mul_issue_ctrl
// Purpose : issue/sequencing stage in front of the approximate Booth
//           multiplier (MUL). Accepts one op at a time, holds the operands on
//           mul_a/mul_x, restarts MUL by releasing mul_reset, waits a fixed
//           MUL_LATENCY cycles, captures mul_result and presents it with its
//           rd tag until writeback takes it.
// Ports   : clk, reset (async, active-high)
//           io         mul_issue_if.slave (in_* request, out_* response)
//           flush      abandon any in-flight or held op (synchronous)
//           mul_reset  restart pin of MUL (1 = held quiescent)
//           mul_a/mul_x operands driven to MUL
//           mul_result product from MUL
//           busy       an op is in flight or being presented
// Config  : MUL_ZERO_BYPASS_EN - when defined, ops with an operand of 0 or 1
//           are answered directly (IDLE->DONE) without restarting MUL.
// -----------------------------------------------------------------------------
module mul_issue_ctrl #(
    parameter int XLEN        = 32,
    parameter int TAG_W       = 5,
    parameter int MUL_LATENCY = 24
) (
    input  logic             clk,
    input  logic             reset,
    mul_issue_if.slave       io,
    input  logic             flush,
    output logic             mul_reset,
    output logic [XLEN-1:0]  mul_a,
    output logic [XLEN-1:0]  mul_x,
    input  logic [XLEN-1:0]  mul_result,
    output logic             busy
);

    // Counter only has to hold MUL_LATENCY-1.
    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] counter_r;
    logic [TAG_W-1:0] tag_r;
    logic             accept_s;
    logic             capture_s;
    logic             bypass_s;
    logic [XLEN-1:0]  bypass_val_s;

    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             mul_reset_r;
    logic [XLEN-1:0]  mul_a_r;
    logic [XLEN-1:0]  mul_x_r;
    logic [XLEN-1:0]  out_result_r;
    logic [TAG_W-1:0] out_tag_r;

`ifdef MUL_ZERO_BYPASS_EN
    // An operand of 0 or 1 makes the product trivial.
    function automatic logic bypass_hit(input logic [XLEN-1:0] a, input logic [XLEN-1:0] x);
        bypass_hit = (a == {XLEN{1'b0}}) || (x == {XLEN{1'b0}}) ||
                     (a == {{(XLEN-1){1'b0}}, 1'b1}) || (x == {{(XLEN-1){1'b0}}, 1'b1});
    endfunction

    // Zero check has priority over the identity checks.
    function automatic logic [XLEN-1:0] bypass_value(input logic [XLEN-1:0] a, input logic [XLEN-1:0] x);
        if ((a == {XLEN{1'b0}}) || (x == {XLEN{1'b0}})) begin
            bypass_value = {XLEN{1'b0}};
        end else if (a == {{(XLEN-1){1'b0}}, 1'b1}) begin
            bypass_value = x;
        end else begin
            bypass_value = a;
        end
    endfunction

    // Trivial-product detection on the offered operands.
    always_comb begin
        bypass_s     = bypass_hit(io.in_a, io.in_x);
        bypass_val_s = bypass_value(io.in_a, io.in_x);
    end
`else
    assign bypass_s     = 1'b0;
    assign bypass_val_s = {XLEN{1'b0}};
`endif

    // Next-state and handshake decode; flush overrides everything else.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (io.in_valid) begin
                        accept_s    = 1'b1;
                        state_nxt_s = bypass_s ? DONE : LAUNCH;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                LAUNCH: state_nxt_s = WAIT;
                WAIT: begin
                    if (counter_r == CNT_ZERO) begin
                        capture_s   = 1'b1;
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register plus status outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            mul_reset_r <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
            busy_r      <= (state_nxt_s != IDLE);
            // MUL runs only while waiting; held in restart otherwise.
            mul_reset_r <= (state_nxt_s != WAIT);
        end
    end

    // Latency counter: loaded in LAUNCH, counts down in WAIT, stops at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_r <= CNT_ZERO;
        end else if (state_r == LAUNCH) begin
            counter_r <= CNT_LOAD;
        end else if ((state_r == WAIT) && (counter_r != CNT_ZERO)) begin
            counter_r <= counter_r - CNT_ONE;
        end else begin
            counter_r <= counter_r;
        end
    end

    // Operand/tag latch on accept and result capture at end of the wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_a_r      <= {XLEN{1'b0}};
            mul_x_r      <= {XLEN{1'b0}};
            tag_r        <= {TAG_W{1'b0}};
            out_result_r <= {XLEN{1'b0}};
            out_tag_r    <= {TAG_W{1'b0}};
        end else if (accept_s) begin
            if (bypass_s) begin
                // MUL is not touched: its operand lines keep the old op.
                out_result_r <= bypass_val_s;
                out_tag_r    <= io.in_tag;
            end else begin
                mul_a_r <= io.in_a;
                mul_x_r <= io.in_x;
                tag_r   <= io.in_tag;
            end
        end else if (capture_s) begin
            out_result_r <= mul_result;
            out_tag_r    <= tag_r;
        end else begin
            out_result_r <= out_result_r;
        end
    end

    assign io.in_ready   = in_ready_r;
    assign io.out_valid  = out_valid_r;
    assign io.out_result = out_result_r;
    assign io.out_tag    = out_tag_r;
    assign busy          = busy_r;
    assign mul_reset     = mul_reset_r;
    assign mul_a         = mul_a_r;
    assign mul_x         = mul_x_r;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_issue_ctrl
// Bench for mul_issue_ctrl with MUL_LATENCY=4 and a stub multiplier that
// drives the exact product only once MUL_LATENCY cycles have elapsed since
// its restart was released (garbage before that).
// -----------------------------------------------------------------------------
module tb_mul_issue_ctrl;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int LAT   = 4;
`ifdef MUL_ZERO_BYPASS_EN
    localparam int BYP_LAT = 1;
`else
    localparam int BYP_LAT = LAT + 2;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             mul_reset;
    logic [XLEN-1:0]  mul_a;
    logic [XLEN-1:0]  mul_x;
    logic [XLEN-1:0]  mul_result;
    logic             busy;

    mul_issue_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    mul_issue_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .io         (bus),
        .flush      (flush),
        .mul_reset  (mul_reset),
        .mul_a      (mul_a),
        .mul_x      (mul_x),
        .mul_result (mul_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stub MUL: exact product LAT cycles after restart release.
    logic [7:0] stub_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset)                 stub_cnt <= 8'd0;
        else if (mul_reset)        stub_cnt <= 8'd0;
        else if (stub_cnt != 8'hFF) stub_cnt <= stub_cnt + 8'd1;
    end
    assign mul_result = (!mul_reset && (stub_cnt >= 8'(LAT - 1))) ? (mul_a * mul_x) : 32'hDEAD_BEEF;

    function automatic logic trivial_op(input logic [31:0] a, input logic [31:0] x);
`ifdef MUL_ZERO_BYPASS_EN
        return (a == 32'd0) || (x == 32'd0) || (a == 32'd1) || (x == 32'd1);
`else
        return 1'b0;
`endif
    endfunction

    // Transaction-level model: an accepted op becomes visible LAT+1 edges
    // later (or immediately when trivial); its value is simply a*x.
    int          cyc;
    int          m_acc;
    int          m_due;
    logic        m_idle;
    logic        m_valid;
    logic [31:0] m_res;
    logic [4:0]  m_tag;
    logic [31:0] m_mul_a;
    logic [31:0] m_mul_x;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc <= 0; m_acc <= 0; m_due <= 0;
            m_idle <= 1'b1; m_valid <= 1'b0;
            m_res <= 32'd0; m_tag <= 5'd0; m_mul_a <= 32'd0; m_mul_x <= 32'd0;
        end else begin
            cyc <= cyc + 1;
            if (flush) begin
                m_idle <= 1'b1;
                m_valid <= 1'b0;
            end else if (m_idle) begin
                if (bus.in_valid) begin
                    m_idle <= 1'b0;
                    m_acc  <= cyc;
                    m_res  <= bus.in_a * bus.in_x;
                    m_tag  <= bus.in_tag;
                    if (trivial_op(bus.in_a, bus.in_x)) begin
                        m_valid <= 1'b1;
                    end else begin
                        m_due   <= cyc + LAT + 1;
                        m_mul_a <= bus.in_a;
                        m_mul_x <= bus.in_x;
                    end
                end
            end else if (!m_valid) begin
                if (cyc == m_due) m_valid <= 1'b1;
            end else if (bus.out_ready) begin
                m_valid <= 1'b0;
                m_idle  <= 1'b1;
            end
        end
    end

    logic [31:0] got[$];

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, m_idle});
            check("busy", {31'd0, busy}, {31'd0, !m_idle});
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
            check("mul_reset", {31'd0, mul_reset},
                  {31'd0, !(!m_idle && !m_valid && (cyc > m_acc + 1))});
            check("mul_a", mul_a, m_mul_a);
            check("mul_x", mul_x, m_mul_x);
            if (m_valid) begin
                check("out_result", bus.out_result, m_res);
                check("out_tag", {27'd0, bus.out_tag}, {27'd0, m_tag});
            end
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_result);
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        check({name, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_mul_reset"}, {31'd0, mul_reset}, 32'd1);
        check({name, "_mul_a"}, mul_a, 32'd0);
        check({name, "_mul_x"}, mul_x, 32'd0);
        check({name, "_out_result"}, bus.out_result, 32'd0);
        check({name, "_out_tag"}, {27'd0, bus.out_tag}, 32'd0);
    endtask

    // Issue one op from IDLE with out_ready=1; n counts samples after E0.
    task automatic run_op(input logic [31:0] a, input logic [31:0] x, input logic [4:0] tag,
                          input logic [31:0] exp_res, input int exp_lat, input string name);
        int n;
        bus.in_a = a; bus.in_x = x; bus.in_tag = tag;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 40) begin
            step();
            n++;
        end
        check({name, "_latency"}, n, exp_lat);
        check({name, "_result"}, bus.out_result, exp_res);
        check({name, "_tag"}, {27'd0, bus.out_tag}, {27'd0, tag});
        step();
        check({name, "_ready_after"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            step();
            n++;
        end
        check({name, "_valid_seen"}, {31'd0, bus.out_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        bus.in_valid = 1'b0; bus.in_a = 32'd0; bus.in_x = 32'd0; bus.in_tag = 5'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("reset");
        step();
        reset = 1'b0;
        step();

        // 1: basic op, 3*2
        run_op(32'd3, 32'd2, 5'd5, 32'd6, LAT + 2, "t1");

        // 2: held result with stalled writeback; in_valid ignored meanwhile
        bus.out_ready = 1'b0;
        bus.in_a = 32'h0106; bus.in_x = 32'h0048; bus.in_tag = 5'd9; bus.in_valid = 1'b1;
        step();
        bus.in_a = 32'hFFFF; bus.in_x = 32'h2; bus.in_tag = 5'd3;
        wait_valid("t2");
        for (int i = 0; i < 10; i++) begin
            step();
            check("t2_hold_result", bus.out_result, 32'h49B0);
            check("t2_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("t2_hold_ready", {31'd0, bus.in_ready}, 32'd0);
            check("t2_hold_mul_a", mul_a, 32'h0106);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        step();
        check("t2_release_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t2_release_ready", {31'd0, bus.in_ready}, 32'd1);

        // 3: back-to-back with in_valid held
        got.delete();
        bus.in_a = 32'd11; bus.in_x = 32'd13; bus.in_tag = 5'd1; bus.in_valid = 1'b1;
        step();
        bus.in_a = 32'h1000; bus.in_x = 32'd3; bus.in_tag = 5'd2;
        n = 0;
        while (!bus.in_ready && n < 40) begin step(); n++; end
        step();
        bus.in_valid = 1'b0;
        n = 0;
        while (busy && n < 40) begin step(); n++; end
        check("t3_count", got.size(), 32'd2);
        if (got.size() >= 2) begin
            check("t3_first", got[0], 32'd143);
            check("t3_second", got[1], 32'h3000);
        end

        // 4: flush in IDLE beats in_valid, then flush in WAIT and in DONE
        bus.in_a = 32'd9; bus.in_x = 32'd9; bus.in_tag = 5'd4; bus.in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; bus.in_valid = 1'b0;
        check("t4_idle_flush_busy", {31'd0, busy}, 32'd0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t4_wait_flush_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t4_wait_flush_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (6) step();
        check("t4_no_late_valid", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_valid("t4_done");
        flush = 1'b1; bus.out_ready = 1'b1;
        step();
        flush = 1'b0;
        check("t4_done_flush_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t4_done_flush_ready", {31'd0, bus.in_ready}, 32'd1);
        run_op(32'd7, 32'h20A, 5'd6, 32'hE46, LAT + 2, "t4");

        // 5: reset in WAIT
        bus.in_a = 32'd4; bus.in_x = 32'd4; bus.in_tag = 5'd11; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step(); step();
        reset = 1'b1;
        #1;
        check_reset_vals("t5_midop");
        step();
        reset = 1'b0;
        step();
        run_op(32'd5, 32'd3, 5'd7, 32'd15, LAT + 2, "t5");

        // 6: trivial operands (bypassed only when the feature is built in)
        run_op(32'd0, 32'd5, 5'd8, 32'd0, BYP_LAT, "t6_zero");
        run_op(32'd1, 32'h1234, 5'd9, 32'h1234, BYP_LAT, "t6_one_a");
        run_op(32'h55, 32'd1, 5'd12, 32'h55, BYP_LAT, "t6_one_x");
        run_op(32'd0, 32'd1, 5'd13, 32'd0, BYP_LAT, "t6_zero_prio");
        run_op(32'd5, 32'd3, 5'd10, 32'd15, LAT + 2, "t6_norm");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
